// File: rtl/cpu_fetch_queue.sv
// Decoupled instruction prefetch queue: streams word fetches from a 1-cycle-latency
// instruction port into a DEPTH-entry buffer and hands them to execute via valid/ready.
module cpu_fetch_queue #(
   parameter int              DEPTH    = 4,
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   output logic                       mem_req_o,
   input  logic                       mem_gnt_i,
   output logic [XLEN-1:0]            mem_addr_o,
   input  logic [XLEN-1:0]            mem_rdata_i,
   input  logic                       redirect_i,
   input  logic [XLEN-1:0]            redirect_pc_i,
   output logic                       ins_valid_o,
   input  logic                       ins_ready_i,
   output logic [XLEN-1:0]            ins_o,
   output logic [XLEN-1:0]            ins_pc_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       err_misaligned_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t             state;
   logic [XLEN-1:0]    fetch_pc;
   logic [XLEN-1:0]    req_pc;
   logic               resp_pending;
   logic [CNT_W-1:0]   count;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               err;

   logic [XLEN-1:0]    ins_mem [DEPTH];
   logic [XLEN-1:0]    pc_mem  [DEPTH];

   logic               running;
   logic               flush;
   logic [CNT_W:0]     credit;
   logic               mem_req;
   logic               accept;
   logic               push;
   logic               pop;
   logic               ins_valid;

   assign running = (state == ST_RUN);
   assign flush   = redirect_i & running;

   // An in-flight response already owns a slot; a same-cycle pop earns no credit.
   assign credit  = {1'b0, count} + {{CNT_W{1'b0}}, resp_pending};
   assign mem_req = rstn_i & running & ~redirect_i & (credit < DEPTH_C);
   assign accept  = mem_req & mem_gnt_i;
   assign push    = resp_pending & running & ~flush;

   assign ins_valid = (count != '0);
   assign pop       = ins_valid & ins_ready_i;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state        <= ST_RUN;
         err          <= 1'b0;
         fetch_pc     <= RESET_PC;
         req_pc       <= RESET_PC;
         resp_pending <= 1'b0;
         count        <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (redirect_i) begin
                  // Flush everything, including the response landing this cycle.
                  resp_pending <= 1'b0;
                  count        <= '0;
                  wr_ptr       <= '0;
                  rd_ptr       <= '0;
                  if (redirect_pc_i[1:0] == 2'b00) begin
                     fetch_pc <= redirect_pc_i;
                  end else begin
                     err   <= 1'b1;
                     state <= ST_HALT;
                  end
               end else begin
                  resp_pending <= accept;
                  if (accept) begin
                     req_pc   <= fetch_pc;
                     fetch_pc <= fetch_pc + XLEN'(4);
                  end
                  if (push) begin
                     wr_ptr <= wr_ptr + PTR_W'(1);
                  end
                  if (pop) begin
                     rd_ptr <= rd_ptr + PTR_W'(1);
                  end
                  case ({push, pop})
                     2'b10:   count <= count + CNT_W'(1);
                     2'b01:   count <= count - CNT_W'(1);
                     default: count <= count;
                  endcase
               end
            end
            ST_HALT: begin
               state <= ST_HALT;
            end
            default: begin
               state <= ST_HALT;
            end
         endcase
      end
   end

   // Payload storage carries no reset; occupancy alone decides what is visible.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk_i) begin
            if (push && (wr_ptr == PTR_W'(gi))) begin
               ins_mem[gi] <= mem_rdata_i;
               pc_mem[gi]  <= req_pc;
            end
         end
      end
   endgenerate

   assign mem_req_o        = mem_req;
   assign mem_addr_o       = fetch_pc;
   assign ins_valid_o      = ins_valid;
   assign ins_o            = ins_valid ? ins_mem[rd_ptr] : '0;
   assign ins_pc_o         = ins_valid ? pc_mem[rd_ptr]  : '0;
   assign count_o          = count;
   assign err_misaligned_o = err;

endmodule
